roce_latency_stats: RTL and testbench

ROCE_LATENCY_STATS -- requirements
Module: roce_latency_stats

---
 rtl/roce_latency_stats_pkg.sv | 21 ++
 rtl/roce_lat_bin_enc.sv | 36 +++
 rtl/roce_latency_stats.sv | 163 ++++++++++++++++
 tb/tb_roce_latency_stats.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roce_latency_stats_pkg.sv
// ============================================================================
// Module : RoCE_params (package)
// Brief  : Shared FSM state encoding and reset constants for latency stats.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package RoCE_params;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Minimum tracker starts at all-ones so any real sample replaces it.
    localparam logic [63:0] C_LAT_MIN_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/roce_lat_bin_enc.sv
// ============================================================================
// Module : roce_lat_bin_enc
// Brief  : log2 histogram bin encoder: MSB position of the sample, clamped.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module roce_lat_bin_enc #(
    parameter int HIST_BINS = 16
) (
    input  logic [63:0]                  i_data,
    output logic [$clog2(HIST_BINS)-1:0] o_bin
);

    localparam int BIN_W = $clog2(HIST_BINS);

    logic [6:0] w_msb;

    // Samples of 0 and 1 both land in bin 0; the loop starts at bit 1.
    always_comb begin
        w_msb = 7'd0;
        for (int i = 1; i < 64; i++) begin
            if (i_data[i]) begin
                w_msb = 7'(i);
            end
        end
        if (int'(w_msb) >= HIST_BINS - 1) begin
            o_bin = BIN_W'(HIST_BINS - 1);
        end else begin
            o_bin = w_msb[BIN_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/roce_latency_stats.sv
// ============================================================================
// Module : roce_latency_stats
// Brief  : Per-run latency statistics (count/min/max/sum/last) + log2 histogram.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module roce_latency_stats
    import RoCE_params::*;
#(
    parameter int HIST_BINS = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [CNT_WIDTH-1:0]         target_count_i,
    input  logic                         s_sample_valid,
    input  logic [63:0]                  s_sample_data,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_WIDTH-1:0]         sample_count_o,
    output logic [63:0]                  lat_min_o,
    output logic [63:0]                  lat_max_o,
    output logic [63:0]                  lat_last_o,
    output logic [63:0]                  lat_sum_o,
    input  logic [$clog2(HIST_BINS)-1:0] hist_rd_addr_i,
    output logic [CNT_WIDTH-1:0]         hist_rd_data_o
);

    localparam int BIN_W = $clog2(HIST_BINS);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_start_d;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_target;
    logic [CNT_WIDTH-1:0] r_count;
    logic [63:0]          r_min;
    logic [63:0]          r_max;
    logic [63:0]          r_sum;
    logic [63:0]          r_last;
    logic [CNT_WIDTH-1:0] r_bins [HIST_BINS];
    logic [CNT_WIDTH-1:0] r_hist_rd_data;

    logic                 w_start_edge;
    logic                 w_clear;
    logic                 w_accept;
    logic [BIN_W-1:0]     w_bin;
    logic [CNT_WIDTH-1:0] w_count_inc;
    logic [64:0]          w_sum_wide;
    logic [63:0]          w_sum_next;
    logic [CNT_WIDTH-1:0] w_bin_inc;
    logic [CNT_WIDTH-1:0] w_hist_next;

    assign w_start_edge = start_i & ~r_start_d;
    assign w_clear      = rst | w_start_edge;
    // A start edge wins over a coincident sample.
    assign w_accept     = (r_state == ST_RUN) & s_sample_valid & ~w_start_edge;

    roce_lat_bin_enc #(
        .HIST_BINS (HIST_BINS)
    ) u_bin_enc (
        .i_data (s_sample_data),
        .o_bin  (w_bin)
    );

    assign w_count_inc = (&r_count) ? r_count : r_count + CNT_WIDTH'(1);
    assign w_sum_wide  = {1'b0, r_sum} + {1'b0, s_sample_data};
    assign w_sum_next  = w_sum_wide[64] ? 64'hFFFF_FFFF_FFFF_FFFF : w_sum_wide[63:0];
    assign w_bin_inc   = (&r_bins[w_bin]) ? r_bins[w_bin] : r_bins[w_bin] + CNT_WIDTH'(1);

    always_comb begin
        w_state_next = r_state;
        if (w_start_edge) begin
            w_state_next = ST_RUN;
        end else if (w_accept && (r_target != '0) && (w_count_inc == r_target)) begin
            w_state_next = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_start_d <= 1'b0;
            r_target  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_busy    <= (w_state_next == ST_RUN);
            r_done    <= (w_state_next == ST_DONE);
            r_start_d <= start_i;
            if (w_start_edge) begin
                r_target <= target_count_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_count <= '0;
            r_min   <= C_LAT_MIN_RESET;
            r_max   <= '0;
            r_sum   <= '0;
            r_last  <= '0;
        end else if (w_accept) begin
            r_count <= w_count_inc;
            r_sum   <= w_sum_next;
            r_last  <= s_sample_data;
            // First sample of a run seeds both extremes.
            if ((r_count == '0) || (s_sample_data < r_min)) begin
                r_min <= s_sample_data;
            end
            if ((r_count == '0) || (s_sample_data > r_max)) begin
                r_max <= s_sample_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int b = 0; b < HIST_BINS; b++) begin
                r_bins[b] <= '0;
            end
        end else if (w_accept) begin
            r_bins[w_bin] <= w_bin_inc;
        end
    end

    // Read port returns the post-update value of the addressed bin.
    always_comb begin
        w_hist_next = '0;
        if (int'(hist_rd_addr_i) < HIST_BINS) begin
            if (w_accept && (w_bin == hist_rd_addr_i)) begin
                w_hist_next = w_bin_inc;
            end else begin
                w_hist_next = r_bins[hist_rd_addr_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_hist_rd_data <= '0;
        end else begin
            r_hist_rd_data <= w_hist_next;
        end
    end

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign sample_count_o = r_count;
    assign lat_min_o      = r_min;
    assign lat_max_o      = r_max;
    assign lat_last_o     = r_last;
    assign lat_sum_o      = r_sum;
    assign hist_rd_data_o = r_hist_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_roce_latency_stats.sv
// ============================================================================
// Module : tb_roce_latency_stats
// Brief  : Self-checking bench for roce_latency_stats (scoreboard + scenarios).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_roce_latency_stats;

    localparam int HB  = 16;
    localparam int CW  = 32;
    localparam int SCW = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [CW-1:0] target = '0;
    logic          valid = 1'b0;
    logic [63:0]   data = '0;
    logic [3:0]    addr = '0;
    logic          busy, done;
    logic [CW-1:0] count, hist;
    logic [63:0]   lmin, lmax, llast, lsum;

    logic           s_start = 1'b0;
    logic [SCW-1:0] s_target = '0;
    logic           s_valid = 1'b0;
    logic [63:0]    s_data = '0;
    logic [3:0]     s_addr = '0;
    logic           s_busy, s_done;
    logic [SCW-1:0] s_count, s_hist;
    logic [63:0]    s_min, s_max, s_last, s_sum;

    roce_latency_stats #(.HIST_BINS(HB), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .target_count_i(target),
        .s_sample_valid(valid), .s_sample_data(data),
        .busy_o(busy), .done_o(done), .sample_count_o(count),
        .lat_min_o(lmin), .lat_max_o(lmax), .lat_last_o(llast), .lat_sum_o(lsum),
        .hist_rd_addr_i(addr), .hist_rd_data_o(hist)
    );

    roce_latency_stats #(.HIST_BINS(HB), .CNT_WIDTH(SCW)) u_sat (
        .clk(clk), .rst(rst), .start_i(s_start), .target_count_i(s_target),
        .s_sample_valid(s_valid), .s_sample_data(s_data),
        .busy_o(s_busy), .done_o(s_done), .sample_count_o(s_count),
        .lat_min_o(s_min), .lat_max_o(s_max), .lat_last_o(s_last), .lat_sum_o(s_sum),
        .hist_rd_addr_i(s_addr), .hist_rd_data_o(s_hist)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [CW-1:0] count;
        logic [63:0]   mn;
        logic [63:0]   mx;
        logic [63:0]   sum;
        logic [63:0]   last;
        logic [CW-1:0] hist;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model of the main instance.
    int          m_state = 0;
    bit          m_sd = 1'b0;
    bit          m_first = 1'b1;
    logic [CW-1:0] m_target = '0;
    logic [CW-1:0] m_count = '0;
    logic [63:0] m_min = ONES, m_max = '0, m_sum = '0, m_last = '0;
    logic [CW-1:0] m_bins [HB];

    function automatic int bin_of(input logic [63:0] d);
        int b = 0;
        for (int i = 0; i < 64; i++) if (d[i]) b = i;
        if (b > HB - 1) b = HB - 1;
        return b;
    endfunction

    task automatic model_clear();
        m_count = '0; m_min = ONES; m_max = '0; m_sum = '0; m_last = '0; m_first = 1'b1;
        for (int i = 0; i < HB; i++) m_bins[i] = '0;
    endtask

    task automatic model_step(input logic r, st, v, input logic [63:0] d,
                              input logic [3:0] a, input logic [CW-1:0] tg);
        logic  e;
        logic [64:0] s;
        exp_t  x;
        int    b;
        e = st & ~m_sd;
        if (r) begin
            m_sd = 1'b0; m_state = 0; m_target = '0; model_clear();
        end else begin
            m_sd = st;
            if (e) begin
                model_clear(); m_state = 1; m_target = tg;
            end else if (m_state == 1 && v) begin
                if (m_first) begin m_min = d; m_max = d; m_first = 1'b0; end
                else begin
                    if (d < m_min) m_min = d;
                    if (d > m_max) m_max = d;
                end
                if (m_count != {CW{1'b1}}) m_count = m_count + 1;
                s = {1'b0, m_sum} + {1'b0, d};
                m_sum = s[64] ? ONES : s[63:0];
                m_last = d;
                b = bin_of(d);
                if (m_bins[b] != {CW{1'b1}}) m_bins[b] = m_bins[b] + 1;
                if (m_target != 0 && m_count == m_target) m_state = 2;
            end
        end
        x.busy = (m_state == 1); x.done = (m_state == 2);
        x.count = m_count; x.mn = m_min; x.mx = m_max; x.sum = m_sum; x.last = m_last;
        x.hist = m_bins[a];
        q.push_back(x);
    endtask

    task automatic cyc(input logic r, st, v, input logic [63:0] d,
                       input logic [3:0] a, input logic [CW-1:0] tg);
        @(posedge clk); #2;
        rst = r; start = st; valid = v; data = d; addr = a; target = tg;
        model_step(r, st, v, d, a, tg);
    endtask

    task automatic idle(input logic [3:0] a);
        cyc(1'b0, 1'b0, 1'b0, 64'd0, a, '0);
    endtask

    task automatic smp(input logic [63:0] d);
        cyc(1'b0, 1'b0, 1'b1, d, 4'd0, '0);
    endtask

    task automatic scyc(input logic st, v, input logic [63:0] d, input logic [3:0] a);
        @(posedge clk); #2;
        s_start = st; s_valid = v; s_data = d; s_addr = a;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total += 5;
            if ({busy, done} !== {mon_e.busy, mon_e.done}) begin
                bad++; $display("FAIL sb_state t=%0t got busy/done=%b%b want %b%b", $time, busy, done, mon_e.busy, mon_e.done);
            end
            if (count !== mon_e.count) begin
                bad++; $display("FAIL sb_count t=%0t got %0d want %0d", $time, count, mon_e.count);
            end
            if ({lmin, lmax} !== {mon_e.mn, mon_e.mx}) begin
                bad++; $display("FAIL sb_minmax t=%0t got %h/%h want %h/%h", $time, lmin, lmax, mon_e.mn, mon_e.mx);
            end
            if ({lsum, llast} !== {mon_e.sum, mon_e.last}) begin
                bad++; $display("FAIL sb_sumlast t=%0t got %h/%h want %h/%h", $time, lsum, llast, mon_e.sum, mon_e.last);
            end
            if (hist !== mon_e.hist) begin
                bad++; $display("FAIL sb_hist t=%0t got %0d want %0d", $time, hist, mon_e.hist);
            end
        end
    end

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 4'd0, '0);
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 4'd0, '0);
        idle(4'd0);
        total++;
        if ({busy, done, count, lmin, lmax, lsum, llast, hist} !== {2'b00, 32'd0, ONES, 64'd0, 64'd0, 64'd0, 32'd0}) begin
            bad++; $display("FAIL reset_vals got busy=%b done=%b cnt=%0d min=%h", busy, done, count, lmin);
        end
    endtask

    task automatic test_idle_ignore();
        smp(64'd5); smp(64'd6); smp(64'd7);
        idle(4'd2);
        total++;
        if ({busy, done, count, lmin, lmax, lsum, llast} !== {2'b00, 32'd0, ONES, 64'd0, 64'd0, 64'd0}) begin
            bad++; $display("FAIL idle_ignore got cnt=%0d min=%h max=%h sum=%0d", count, lmin, lmax, lsum);
        end
    endtask

    task automatic test_basic();
        cyc(1'b0, 1'b1, 1'b0, 64'd0, 4'd0, 32'd4);
        smp(64'd10); smp(64'd3); smp(64'd200); smp(64'd3);
        idle(4'd1);
        total++;
        if ({count, lmin, lmax, lsum, llast} !== {32'd4, 64'd3, 64'd200, 64'd216, 64'd3}) begin
            bad++; $display("FAIL basic_stats got cnt=%0d min=%0d max=%0d sum=%0d last=%0d", count, lmin, lmax, lsum, llast);
        end
        total++;
        if ({busy, done} !== 2'b01) begin
            bad++; $display("FAIL basic_done got busy=%b done=%b want 0 1", busy, done);
        end
        idle(4'd3);
        total++;
        if (hist !== 32'd2) begin bad++; $display("FAIL basic_bin1 got %0d want 2", hist); end
        idle(4'd7);
        total++;
        if (hist !== 32'd1) begin bad++; $display("FAIL basic_bin3 got %0d want 1", hist); end
        idle(4'd0);
        total++;
        if (hist !== 32'd1) begin bad++; $display("FAIL basic_bin7 got %0d want 1", hist); end
    endtask

    task automatic test_done_ignore();
        cyc(1'b0, 1'b1, 1'b0, 64'd0, 4'd0, 32'd2);
        smp(64'd8); smp(64'd9);
        for (int i = 1; i <= 5; i++) smp(64'(i));
        idle(4'd0);
        total++;
        if ({done, count, lmin, lmax, lsum, llast} !== {1'b1, 32'd2, 64'd8, 64'd9, 64'd17, 64'd9}) begin
            bad++; $display("FAIL done_ignore got done=%b cnt=%0d min=%0d max=%0d sum=%0d", done, count, lmin, lmax, lsum);
        end
    endtask

    task automatic test_collision();
        cyc(1'b0, 1'b1, 1'b1, 64'd50, 4'd0, 32'd0);
        idle(4'd0);
        total++;
        if ({busy, count, lmin} !== {1'b1, 32'd0, ONES}) begin
            bad++; $display("FAIL collision got busy=%b cnt=%0d min=%h want 1 0 all-ones", busy, count, lmin);
        end
    endtask

    task automatic test_clamp();
        cyc(1'b0, 1'b1, 1'b0, 64'd0, 4'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 64'd1 << 40, 4'd15, '0);
        idle(4'd15);
        total++;
        if (hist !== 32'd1) begin bad++; $display("FAIL clamp_bin15 got %0d want 1", hist); end
    endtask

    task automatic test_midrun_reset();
        cyc(1'b0, 1'b1, 1'b0, 64'd0, 4'd0, 32'd0);
        smp(64'd4); smp(64'd5);
        cyc(1'b1, 1'b0, 1'b1, 64'd6, 4'd0, '0);
        idle(4'd0);
        total++;
        if ({busy, done, count, lmin, lmax, lsum, llast} !== {2'b00, 32'd0, ONES, 64'd0, 64'd0, 64'd0}) begin
            bad++; $display("FAIL midrun_reset got busy=%b cnt=%0d min=%h sum=%0d", busy, count, lmin, lsum);
        end
        cyc(1'b0, 1'b1, 1'b0, 64'd0, 4'd0, 32'd0);
        smp(64'd7);
        idle(4'd0);
        total++;
        if ({count, lmin, lmax} !== {32'd1, 64'd7, 64'd7}) begin
            bad++; $display("FAIL restart got cnt=%0d min=%0d max=%0d want 1 7 7", count, lmin, lmax);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        cyc(1'b0, 1'b1, 1'b0, 64'd0, 4'd0, 32'd0);
        for (int i = 0; i < 60; i++) begin
            d = {$urandom, $urandom} >> $urandom_range(0, 63);
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), d, 4'($urandom_range(0, 15)), '0);
        end
        smp(64'h8000_0000_0000_0000);
        smp(64'h8000_0000_0000_0000);
        idle(4'd0);
        total++;
        if (lsum !== ONES) begin bad++; $display("FAIL sum_sat got %h want all-ones", lsum); end
    endtask

    task automatic test_sat();
        scyc(1'b1, 1'b0, 64'd0, 4'd0);
        for (int i = 0; i < 20; i++) scyc(1'b0, 1'b1, 64'd0, 4'd0);
        scyc(1'b0, 1'b0, 64'd0, 4'd0);
        total++;
        if ({s_busy, s_count, s_sum} !== {1'b1, 4'd15, 64'd0}) begin
            bad++; $display("FAIL cnt_sat got busy=%b cnt=%0d sum=%0d want 1 15 0", s_busy, s_count, s_sum);
        end
        scyc(1'b0, 1'b0, 64'd0, 4'd0);
        total++;
        if (s_hist !== 4'd15) begin bad++; $display("FAIL bin_sat got %0d want 15", s_hist); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic();
        test_done_ignore();
        test_collision();
        test_clamp();
        test_midrun_reset();
        test_back_to_back();
        test_sat();
        @(posedge clk); #3;
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL sb_drain got %0d pending want 0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
